// File: rtl/led_seq_pkg.sv
// Shared constants and types for the Avalon LED sequencer.
// Mode encodings, FSM states and bounce direction live here.
package led_seq_pkg;

    localparam int LED_W_DEF = 8;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED_RD,
        ST_WR,
        ST_WAIT_TICK
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/avalon_led_sequencer_if.sv
// Avalon-MM bus bundle between the sequencer (master)
// and the LED register slave.
interface avalon_led_sequencer_if;

    logic        address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output waitrequest
    );

endinterface

// File: rtl/led_pattern_next.sv
// Combinational next-pattern function for the LED animation.
// Bounce reverses at either end; count wraps naturally.
module led_pattern_next
    import led_seq_pkg::*;
#(
    parameter int LED_W = LED_W_DEF
) (
    input  logic [LED_W-1:0] p,
    input  logic [1:0]       mode,
    input  dir_t             dir,
    output logic [LED_W-1:0] nxt,
    output dir_t             dir_nxt
);

    always_comb begin
        nxt     = p;
        dir_nxt = dir;
        unique case (mode)
            MODE_ROTL: nxt = {p[LED_W-2:0], p[LED_W-1]};
            MODE_ROTR: nxt = {p[0], p[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (p[LED_W-1]) begin
                        dir_nxt = DIR_RIGHT;
                        nxt     = p >> 1;
                    end else begin
                        nxt = p << 1;
                    end
                end else begin
                    if (p[0]) begin
                        dir_nxt = DIR_LEFT;
                        nxt     = p << 1;
                    end else begin
                        nxt = p >> 1;
                    end
                end
            end
            MODE_COUNT: nxt = p + LED_W'(1);
        endcase
    end

endmodule

// File: rtl/avalon_led_sequencer.sv
// Avalon-MM master that seeds from the LED register once,
// then rewrites it with an animated pattern every tick.
module avalon_led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 4,
    parameter int LED_W       = LED_W_DEF
) (
    input  logic                    clock_clk,
    input  logic                    reset_reset_n,
    input  logic                    enable,
    input  logic [1:0]              mode,
    avalon_led_sequencer_if.master  avm_m0,
    output logic [LED_W-1:0]        pattern,
    output logic                    busy
);

    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] nxt_q, nxt_d;
    logic [LED_W-1:0] pattern_q, pattern_d;
    dir_t             dir_q, dir_d;

    logic [LED_W-1:0] seed;
    logic [LED_W-1:0] f_nxt;
    dir_t             f_dir;
    logic             unused_rd;

    assign unused_rd = ^avm_m0.readdata;

    led_pattern_next #(
        .LED_W (LED_W)
    ) u_next (
        .p       (pattern_q),
        .mode    (mode),
        .dir     (dir_q),
        .nxt     (f_nxt),
        .dir_nxt (f_dir)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nxt_d     = nxt_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;

        // An all-zero seed would freeze every mode except count.
        seed = avm_m0.readdata[LED_W-1:0];
        if (seed == '0 && mode != MODE_COUNT) begin
            seed = LED_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SEED_RD;
                end
            end
            ST_SEED_RD: begin
                if (!avm_m0.waitrequest) begin
                    nxt_d   = seed;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!avm_m0.waitrequest) begin
                    pattern_d = nxt_q;
                    cnt_d     = '0;
                    state_d   = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            ST_WAIT_TICK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    nxt_d   = f_nxt;
                    dir_d   = f_dir;
                    state_d = ST_WR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            nxt_q     <= '0;
            pattern_q <= '0;
            dir_q     <= DIR_LEFT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nxt_q     <= nxt_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
        end
    end

    assign avm_m0.address   = 1'b0;
    assign avm_m0.read      = (state_q == ST_SEED_RD);
    assign avm_m0.write     = (state_q == ST_WR);
    assign avm_m0.writedata = avm_m0.write ? 32'(nxt_q) : '0;
    assign pattern          = pattern_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avalon_led_sequencer.sv
// Self-checking bench: stalling slave model plus an
// arithmetic reference of the LED animation rules.
module tb_avalon_led_sequencer;

    localparam int T = 4;

    typedef struct {
        logic [31:0] data;
        int          start;
        int          acc;
        int          hold;
    } wr_rec_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode_i;
    logic [7:0] pattern;
    logic       busy;

    avalon_led_sequencer_if bus ();

    avalon_led_sequencer #(
        .TICK_CYCLES (T),
        .LED_W       (8)
    ) dut (
        .clock_clk     (clk),
        .reset_reset_n (rst_n),
        .enable        (enable),
        .mode          (mode_i),
        .avm_m0        (bus),
        .pattern       (pattern),
        .busy          (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    int        cyc = 0;
    int        stall_cfg = 0;
    int        rem = 0;
    int        hold = 0;
    int        wr_start = 0;
    int        rd_acc = 0;
    int        rd_hold = 0;
    int        n_reads = 0;
    bit        in_xfer = 0;
    bit        mon_on = 0;
    logic      wr_q;
    logic [31:0] held_wd;
    logic [7:0]  exp_pat = '0;
    wr_rec_t   log_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and bus monitor, both working on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            chk("pattern", {56'd0, pattern}, {56'd0, exp_pat});
            chk("rd_wr_excl", {62'd0, bus.read & bus.write, bus.address}, 64'd0);
        end
        wr_q = 1'b0;
        if (!rst_n) begin
            mon_on  = 1;
            exp_pat = '0;
            in_xfer = 0;
            hold    = 0;
        end else if (bus.read || bus.write) begin
            if (!in_xfer) begin
                in_xfer = 1;
                rem     = stall_cfg;
                hold    = 0;
            end
            hold++;
            if (bus.write && hold > 1)
                chk("wd_stable", {32'd0, bus.writedata}, {32'd0, held_wd});
            if (bus.write && hold == 1) wr_start = cyc;
            held_wd = bus.writedata;
            if (rem > 0) begin
                wr_q = 1'b1;
                rem--;
            end else begin
                in_xfer = 0;
                if (bus.write) begin
                    log_q.push_back('{bus.writedata, wr_start, cyc, hold});
                    exp_pat = bus.writedata[7:0];
                end else begin
                    rd_acc  = cyc;
                    rd_hold = hold;
                    n_reads++;
                end
            end
        end else begin
            in_xfer = 0;
        end
        bus.waitrequest = wr_q;
    end

    task automatic model_step(input int p, input int m, input int d,
                              output int p_o, output int d_o);
        d_o = d;
        case (m)
            0: p_o = ((p << 1) | (p >> 7)) % 256;
            1: p_o = (p >> 1) | ((p % 2) << 7);
            2: begin
                if (d == 0) begin
                    if (p >= 128) begin d_o = 1; p_o = p / 2; end
                    else p_o = (p * 2) % 256;
                end else begin
                    if (p % 2 == 1) begin d_o = 0; p_o = (p * 2) % 256; end
                    else p_o = p / 2;
                end
            end
            default: p_o = (p + 1) % 256;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_write(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.write) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) begin ok = 1; break; end
        end
        chk(tag, {63'd0, ok}, 64'd1);
    endtask

    task automatic run_case(input int m, input int sd, input int s,
                            input int n);
        bit ok = 0;
        int p, d, p_n, d_n;
        do_reset();
        stall_cfg    = s;
        bus.readdata = 32'(sd) | 32'hA5A5_0000;
        mode_i       = 2'(m);
        log_q.delete();
        n_reads = 0;
        enable  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (log_q.size() >= n) begin ok = 1; break; end
        end
        chk("run_timeout", {63'd0, ok}, 64'd1);
        enable = 1'b0;
        wait_idle("run_idle");
        if (ok) begin
            p = sd % 256;
            if (p == 0 && m != 3) p = 1;
            d = 0;
            chk("n_reads", 64'(n_reads), 64'd1);
            chk("rd_hold", 64'(rd_hold), 64'(s + 1));
            chk("rd_to_wr", 64'(log_q[0].start - rd_acc), 64'd1);
            for (int i = 0; i < n; i++) begin
                chk("wdata", {32'd0, log_q[i].data}, 64'(p));
                chk("wr_hold", 64'(log_q[i].hold), 64'(s + 1));
                if (i > 0)
                    chk("period", 64'(log_q[i].acc - log_q[i-1].acc),
                        64'(T + 1 + s));
                model_step(p, m, d, p_n, d_n);
                p = p_n;
                d = d_n;
            end
        end
    endtask

    initial begin
        bit ok;
        int sd;
        rst_n           = 1'b0;
        enable          = 1'b0;
        mode_i          = 2'd0;
        bus.readdata    = '0;
        bus.waitrequest = 1'b0;

        // Reset then idle with enable low.
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outs", {20'd0, bus.read, bus.write, busy, pattern,
                 bus.writedata, bus.address}, 64'd0);
        end

        run_case(0, 8'h00, 0, 10);
        run_case(2, 8'h40, 0, 16);
        run_case(3, 8'hFE, 0, 4);
        run_case($urandom_range(0, 3), $urandom_range(0, 255), 3, 5);
        for (int k = 0; k < 4; k++)
            run_case($urandom_range(0, 3), $urandom_range(0, 255),
                     $urandom_range(0, 3), 6);

        // Enable dropped while a stalled write is pending.
        do_reset();
        stall_cfg    = 5;
        sd           = $urandom_range(2, 255);
        bus.readdata = 32'(sd);
        mode_i       = 2'd0;
        log_q.delete();
        n_reads = 0;
        enable  = 1'b1;
        wait_write(ok);
        chk("drop_wr_seen", {63'd0, ok}, 64'd1);
        enable = 1'b0;
        repeat (20) step();
        chk("drop_wr_count", 64'(log_q.size()), 64'd1);
        chk("drop_busy", {63'd0, busy}, 64'd0);
        chk("drop_pattern", {56'd0, pattern}, 64'(sd));
        chk("drop_reads", 64'(n_reads), 64'd1);
        if (log_q.size() > 0)
            chk("drop_hold", 64'(log_q[0].hold), 64'd6);

        // Reset asserted in the middle of a stalled write.
        do_reset();
        stall_cfg = 5;
        log_q.delete();
        enable = 1'b1;
        wait_write(ok);
        chk("rst_wr_seen", {63'd0, ok}, 64'd1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_wr", {61'd0, bus.write, bus.read, busy}, 64'd0);
        chk("rst_no_accept", 64'(log_q.size()), 64'd0);
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
